// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the register-bank write arbiter.
// No logic; elaboration-time constants only.
// Imported by rr_pick and reg_write_arbiter.
package reg_arb_pkg;

   // Upper bound on requesters any arbiter built from rr_pick is sized for
   localparam int MAX_REQ = 8;

   typedef enum logic {
      ARB  = 1'b0,
      LOCK = 1'b1
   } arb_state_t;

   // Index width that never collapses to zero bits (a 1-entry space still needs a wire)
   function automatic int clog2_min1(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping N-1 -> 0.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides what to do with the pick.
module rr_pick
   import reg_arb_pkg::*;
#(
   parameter  int N     = 4,
   localparam int IDX_W = clog2_min1(N)
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic             o_vld,
   output logic [IDX_W-1:0] o_idx
);

   logic [IDX_W:0] cand;

   // Walk offsets from farthest to nearest so the nearest requester to ptr wins
   always_comb begin
      o_vld = 1'b0;
      o_idx = '0;
      cand  = '0;
      for (int i = N - 1; i >= 0; i--) begin
         cand = {1'b0, i_ptr} + (IDX_W + 1)'(i);
         if (cand >= (IDX_W + 1)'(N)) begin
            cand = cand - (IDX_W + 1)'(N);
         end
         if (i_req[cand[IDX_W-1:0]]) begin
            o_vld = 1'b1;
            o_idx = cand[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter giving NUM_REQ writers one register-bank write per cycle.
// Latency: req sampled at edge N -> ack/ld/data valid in cycle N+1; bank loads at N+2.
// Backpressure: requesters hold req until ack; bus lock via REG_ARB_LOCK_EN macro.
module reg_write_arbiter
   import reg_arb_pkg::*;
#(
   parameter  int NUM_REQ  = 4,
   parameter  int NUM_REGS = 4,
   parameter  int BITS     = 8,
   localparam int ADDR_W   = clog2_min1(NUM_REGS),
   localparam int IDX_W    = clog2_min1(NUM_REQ)
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [NUM_REQ-1:0]        i_req,
   input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
   input  logic [NUM_REQ*BITS-1:0]   i_wdata,
`ifdef REG_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]        i_lock,
`endif
   output logic [NUM_REQ-1:0]        o_ack,
   output logic [NUM_REGS-1:0]       o_ld,
   output logic [BITS-1:0]           o_data,
   output logic                      o_err,
   output logic                      o_busy
);

   arb_state_t          state_q;
   logic [IDX_W-1:0]    ptr_q;
   logic [NUM_REQ-1:0]  mask_q;
   logic [NUM_REQ-1:0]  lock_ok;
   logic [NUM_REQ-1:0]  elig;
   logic                pick_vld;
   logic [IDX_W-1:0]    pick_idx;
   logic [IDX_W-1:0]    ptr_inc;
   logic [ADDR_W-1:0]   sel_addr;
   logic [BITS-1:0]     sel_data;
   logic                addr_bad;
   logic [NUM_REQ-1:0]  gnt_oh;
   logic [NUM_REGS-1:0] ld_nxt;

`ifdef REG_ARB_LOCK_EN
   logic [IDX_W-1:0]    owner_q;

   // While locked only the owner is allowed to compete
   always_comb begin
      lock_ok = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         lock_ok[k] = (state_q == ARB) || (owner_q == IDX_W'(k));
      end
   end
`else
   assign lock_ok = {NUM_REQ{1'b1}};
`endif

   // A requester acked this cycle still shows its old req; hide it for one cycle
   assign elig = i_req & ~mask_q & lock_ok;

   rr_pick #(
      .N (NUM_REQ)
   ) u_pick (
      .i_req (elig),
      .i_ptr (ptr_q),
      .o_vld (pick_vld),
      .o_idx (pick_idx)
   );

   assign ptr_inc = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);

   // Route the winner's address and data; build its one-hot grant
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      gnt_oh   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (pick_idx == IDX_W'(k)) begin
            sel_addr  = i_addr[k*ADDR_W +: ADDR_W];
            sel_data  = i_wdata[k*BITS +: BITS];
            gnt_oh[k] = pick_vld;
         end
      end
   end

   // Addresses past the end of a non-power-of-2 bank are acked but never strobed
   assign addr_bad = ({1'b0, sel_addr} >= (ADDR_W + 1)'(NUM_REGS));

   // Decode the load strobe: at most one register per cycle
   always_comb begin
      ld_nxt = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         ld_nxt[r] = pick_vld && !addr_bad && (sel_addr == ADDR_W'(r));
      end
   end

   // Registered outputs, pointer, issue mask and lock FSM
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ARB;
         ptr_q   <= '0;
         mask_q  <= '0;
         o_ack   <= '0;
         o_ld    <= '0;
         o_data  <= '0;
         o_err   <= 1'b0;
         o_busy  <= 1'b0;
`ifdef REG_ARB_LOCK_EN
         owner_q <= '0;
`endif
      end else begin
         o_ack  <= gnt_oh;
         mask_q <= gnt_oh;
         o_ld   <= ld_nxt;
         o_data <= pick_vld ? sel_data : '0;
         o_err  <= pick_vld & addr_bad;
         // A grant this cycle keeps us busy; otherwise only a held lock does
         o_busy <= pick_vld | (state_q == LOCK);
         if (pick_vld) begin
            ptr_q <= ptr_inc;
`ifdef REG_ARB_LOCK_EN
            if (i_lock[pick_idx]) begin
               state_q <= LOCK;
               owner_q <= pick_idx;
            end else begin
               state_q <= ARB;
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a queue-free behavioural model.
// Two DUTs share stimulus: a 4-register bank and a 3-register bank (bad-address case).
// Model compared every cycle; literal checks pin the directed scenarios.
module tb_reg_write_arbiter;

`ifdef REG_ARB_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [7:0] addr;
   logic [31:0] wdata;
   logic [3:0] lock;

   logic [3:0] ack4, ld4;
   logic [7:0] data4;
   logic       err4, busy4;
   logic [3:0] ack3;
   logic [2:0] ld3;
   logic [7:0] data3;
   logic       err3, busy3;

   int errors = 0;
   int checks = 0;

   reg_write_arbiter #(.NUM_REQ(4), .NUM_REGS(4), .BITS(8)) dut4 (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_req   (req),
      .i_addr  (addr),
      .i_wdata (wdata),
`ifdef REG_ARB_LOCK_EN
      .i_lock  (lock),
`endif
      .o_ack   (ack4),
      .o_ld    (ld4),
      .o_data  (data4),
      .o_err   (err4),
      .o_busy  (busy4)
   );

   reg_write_arbiter #(.NUM_REQ(4), .NUM_REGS(3), .BITS(8)) dut3 (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_req   (req),
      .i_addr  (addr),
      .i_wdata (wdata),
`ifdef REG_ARB_LOCK_EN
      .i_lock  (lock),
`endif
      .o_ack   (ack3),
      .o_ld    (ld3),
      .o_data  (data3),
      .o_err   (err3),
      .o_busy  (busy3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int  m_ptr, m_last, m_owner;
   bit  m_locked;
   bit  m_valid = 1'b0;
   logic [3:0] e_ack, e_ld4;
   logic [2:0] e_ld3;
   logic [7:0] e_data;
   logic       e_err4, e_err3, e_busy;

   always @(posedge clk) begin : model
      int found, k, a;
      if (rst) begin
         m_ptr = 0; m_last = -1; m_locked = 0; m_owner = 0;
         e_ack = 0; e_ld4 = 0; e_ld3 = 0; e_data = 0;
         e_err4 = 0; e_err3 = 0; e_busy = 0;
         m_valid = 1'b1;
      end else begin
         found = -1;
         for (int j = 0; j < 4; j++) begin
            k = (m_ptr + j) % 4;
            if (found < 0 && req[k] && k != m_last && (!m_locked || k == m_owner))
               found = k;
         end
         e_ack = 0; e_ld4 = 0; e_ld3 = 0; e_data = 0; e_err4 = 0; e_err3 = 0;
         if (found >= 0) begin
            e_ack[found] = 1'b1;
            a = int'(addr[found*2 +: 2]);
            e_ld4[a] = 1'b1;
            if (a < 3) e_ld3[a] = 1'b1; else e_err3 = 1'b1;
            e_data = wdata[found*8 +: 8];
            m_ptr = (found + 1) % 4;
            if (LOCK_EN) begin
               m_locked = lock[found];
               m_owner  = found;
            end
         end
         m_last = found;
         e_busy = (found >= 0) || m_locked;
      end
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (m_valid) begin
         chk("m_ack4", 32'(ack4), 32'(e_ack));
         chk("m_ld4", 32'(ld4), 32'(e_ld4));
         chk("m_data4", 32'(data4), 32'(e_data));
         chk("m_err4", 32'(err4), 32'(e_err4));
         chk("m_busy4", 32'(busy4), 32'(e_busy));
         chk("m_ack3", 32'(ack3), 32'(e_ack));
         chk("m_ld3", 32'(ld3), 32'(e_ld3));
         chk("m_err3", 32'(err3), 32'(e_err3));
      end
   end

   // Consumer register bank, loads on the edge after the strobe
   logic [7:0] bank4 [4];
   always @(posedge clk) begin
      for (int r = 0; r < 4; r++) if (ld4[r]) bank4[r] <= data4;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      lock = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   int order[$];
   int busy_cnt, strobe_cnt, w0;

   initial begin : stim
      rst = 1'b1;
      req = 4'b1111;
      lock = '0;
      addr = {2'd3, 2'd2, 2'd1, 2'd0};
      wdata = {8'h44, 8'h33, 8'h22, 8'h11};
      for (int r = 0; r < 4; r++) bank4[r] = '0;

      // 1. reset held two edges with every req high
      @(negedge clk);
      @(negedge clk);
      chk("rst_ack", 32'(ack4), 32'h0);
      chk("rst_ld", 32'(ld4), 32'h0);
      chk("rst_data", 32'(data4), 32'h0);
      chk("rst_busy", 32'(busy4), 32'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("first_ack", 32'(ack4), 32'h1);
      chk("first_data", 32'(data4), 32'h11);
      req = '0;
      @(negedge clk);

      // 2. single write, req kept through its ack cycle to exercise the mask
      req = 4'b0010;
      addr[3:2] = 2'd2;
      wdata[15:8] = 8'hA5;
      @(negedge clk);
      chk("single_ack", 32'(ack4), 32'h2);
      chk("single_ld", 32'(ld4), 32'h4);
      chk("single_data", 32'(data4), 32'hA5);
      @(negedge clk);
      chk("single_norepeat", 32'(ack4), 32'h0);
      req = '0;
      @(negedge clk);
      chk("single_idle", 32'(ld4), 32'h0);

      // 3. fairness: all request, each drops after its ack
      do_reset();
      addr = {2'd3, 2'd2, 2'd1, 2'd0};
      wdata = {8'h44, 8'h33, 8'h22, 8'h11};
      req = 4'b1111;
      busy_cnt = 0;
      order.delete();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (busy4) busy_cnt++;
         for (int k = 0; k < 4; k++) if (ack4[k]) order.push_back(k);
         req = req & ~ack4;
      end
      chk("fair_count", 32'(order.size()), 32'd4);
      for (int i = 0; i < 4 && i < order.size(); i++)
         chk("fair_order", 32'(order[i]), 32'(i));
      chk("fair_busy", 32'(busy_cnt), 32'd4);
      req = 4'b1001;
      @(negedge clk);
      chk("ptr_wrap", 32'(ack4), 32'h1);
      req = '0;
      @(negedge clk);

      // 4. contention on register 1
      do_reset();
      addr = {2'd0, 2'd1, 2'd0, 2'd1};
      wdata = {8'h00, 8'h22, 8'h00, 8'h11};
      req = 4'b0101;
      strobe_cnt = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (ld4[1]) strobe_cnt++;
         req = req & ~ack4;
      end
      chk("cont_strobes", 32'(strobe_cnt), 32'd2);
      chk("cont_bank1", 32'(bank4[1]), 32'h22);

      // 5. address 3 is past the end of the 3-register bank
      addr[1:0] = 2'd3;
      wdata[7:0] = 8'h5C;
      req = 4'b0001;
      @(negedge clk);
      chk("bad_ack3", 32'(ack3), 32'h1);
      chk("bad_err3", 32'(err3), 32'h1);
      chk("bad_ld3", 32'(ld3), 32'h0);
      chk("bad_ld4", 32'(ld4), 32'h8);
      chk("bad_err4", 32'(err4), 32'h0);
      req = '0;
      @(negedge clk);

`ifdef REG_ARB_LOCK_EN
      // 6. locked burst of three writes from requester 0 ahead of requester 1
      do_reset();
      addr = {2'd0, 2'd0, 2'd1, 2'd0};
      wdata = {8'h00, 8'h00, 8'h70, 8'h60};
      lock = 4'b0001;
      req = 4'b0011;
      w0 = 0;
      order.delete();
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         for (int k = 0; k < 4; k++) if (ack4[k]) order.push_back(k);
         if (ack4[0]) begin
            w0++;
            wdata[7:0] = 8'(8'h60 + w0);
            lock[0] = (w0 < 2);
            if (w0 == 3) req[0] = 1'b0;
         end
         if (ack4[1]) req[1] = 1'b0;
      end
      chk("lock_count", 32'(order.size()), 32'd4);
      if (order.size() == 4) begin
         chk("lock_o0", 32'(order[0]), 32'd0);
         chk("lock_o1", 32'(order[1]), 32'd0);
         chk("lock_o2", 32'(order[2]), 32'd0);
         chk("lock_o3", 32'(order[3]), 32'd1);
      end
      // Lock taken, owner goes idle, requester 1 waits; reset releases it
      lock = 4'b0001;
      req = 4'b0001;
      @(negedge clk);
      chk("lock2_ack", 32'(ack4), 32'h1);
      req = 4'b0010;
      for (int c = 0; c < 3; c++) @(negedge clk);
      chk("lock2_held", 32'(ack4), 32'h0);
      chk("lock2_busy", 32'(busy4), 32'h1);
      rst = 1'b1;
      @(negedge clk);
      chk("lock2_rst_busy", 32'(busy4), 32'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("lock2_release", 32'(ack4), 32'h2);
      req = '0;
      lock = '0;
      @(negedge clk);
`endif

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
